// File: rtl/alu_issue_unit.sv
// Issue stage for the 4-bit ALU: register file, valid/ready intake, operand issue to the
// external combinational ALU and single-cycle writeback of its result.
module alu_issue_unit #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IDX_W-1:0]  in_dst,
  input  logic [IDX_W-1:0]  in_src_s,
  input  logic [IDX_W-1:0]  in_src_t,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] alu_rs,
  output logic [DATA_W-1:0] alu_rt,
  input  logic [DATA_W-1:0] alu_rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_dst,
  input  logic [IDX_W-1:0]  peek_idx,
  output logic [DATA_W-1:0] peek_data
);

  localparam int unsigned NumRegs = 2 ** IDX_W;

  typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

  state_e state_q, state_d;

  logic accept, load_we, wb_we;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [IDX_W-1:0]  dst_q;
  logic [2:0]        sel_q;
  logic [DATA_W-1:0] rs_q, rt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_dst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A load owns the register file for its cycle, so it blocks the accept.
  always_comb begin
    in_ready = (state_q == StIdle) && !load_en;
    accept   = in_valid && in_ready;
    load_we  = (state_q == StIdle) && load_en;
    wb_we    = (state_q == StIssue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
      dst_q       <= '0;
      sel_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else begin
      out_valid_q <= wb_we;
      // Operands are read at accept, so dst aliasing a source sees the old value.
      if (accept) begin
        dst_q <= in_dst;
        sel_q <= in_op;
        rs_q  <= regs_q[in_src_s];
        rt_q  <= regs_q[in_src_t];
      end
      if (load_we) begin
        regs_q[load_idx] <= load_data;
      end
      if (wb_we) begin
        regs_q[dst_q] <= alu_rd;
        out_data_q    <= alu_rd;
        out_dst_q     <= dst_q;
      end
    end
  end

  assign alu_sel   = sel_q;
  assign alu_rs    = rs_q;
  assign alu_rt    = rt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dst   = out_dst_q;
  assign peek_data = regs_q[peek_idx];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: directed instructions push hand-computed results,
// a negedge monitor pops and checks every writeback pulse including its latency.
module tb_alu_issue_unit;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [1:0] in_dst, in_src_s, in_src_t;
  logic       load_en;
  logic [1:0] load_idx;
  logic [3:0] load_data;
  logic [2:0] alu_sel;
  logic [3:0] alu_rs, alu_rt, alu_rd;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_dst;
  logic [1:0] peek_idx;
  logic [3:0] peek_data;

  alu_issue_unit #(.DATA_W(4), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dst(in_dst), .in_src_s(in_src_s), .in_src_t(in_src_t),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .alu_sel(alu_sel), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_rd(alu_rd),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst),
    .peek_idx(peek_idx), .peek_data(peek_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU that the unit drives.
  always_comb begin
    alu_rd = '0;
    case (alu_sel)
      3'd0: alu_rd = alu_rs + alu_rt;
      3'd1: alu_rd = alu_rs - alu_rt;
      3'd2: alu_rd = alu_rs & alu_rt;
      3'd3: alu_rd = alu_rs | alu_rt;
      3'd4: alu_rd = {alu_rs[2:0], alu_rs[3]};
      3'd5: alu_rd = {alu_rt[3], alu_rt[3:1]};
      3'd6: alu_rd = {3'b000, alu_rs == alu_rt};
      3'd7: alu_rd = {3'b000, alu_rs > alu_rt};
      default: alu_rd = '0;
    endcase
  end

  typedef struct {
    int dst;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: dst %0d data %0d with nothing expected", out_dst,
                 out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", int'(out_data), e.data);
        check("wb_dst", int'(out_dst), e.dst);
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_instr(input int op, input int d, input int s, input int t);
    in_op    = 3'(op);
    in_dst   = 2'(d);
    in_src_s = 2'(s);
    in_src_t = 2'(t);
  endtask

  task automatic push_exp(input int d, input int data);
    exp_t e;
    e.dst  = d;
    e.data = data;
    e.cyc  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic issue(input int op, input int d, input int s, input int t, input int exp);
    int n = 0;
    @(negedge clk);
    set_instr(op, d, s, t);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", int'(in_ready), 1);
    if (in_ready) push_exp(d, exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input int idx, input int data);
    @(negedge clk);
    load_en   = 1'b1;
    load_idx  = 2'(idx);
    load_data = 4'(data);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic peek(input int idx, input int exp);
    peek_idx = 2'(idx);
    #1;
    check($sformatf("peek_r%0d", idx), int'(peek_data), exp);
  endtask

  int pulses;
  int k;
  int b2b_ready [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
  int b2b_res   [3] = '{6, 13, 4};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; load_en = 1'b0; load_idx = '0; load_data = '0;
    peek_idx = '0;
    set_instr(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_out_valid", int'(out_valid), 0);
    check("rst_alu_sel", int'(alu_sel), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) peek(i, 0);

    load(1, 7);
    load(2, 12);
    peek(1, 7);
    peek(2, 12);

    issue(0, 3, 1, 2, 3);    // add 7+12 wraps
    drain();
    peek(3, 3);
    issue(1, 0, 1, 2, 11);   // sub 7-12 wraps
    issue(7, 3, 2, 1, 1);    // gt 12>7
    issue(6, 3, 1, 2, 0);    // eq 7==12
    issue(4, 3, 1, 0, 14);   // rotl 0111
    issue(5, 3, 0, 2, 14);   // asr 1100
    issue(3, 0, 0, 1, 15);   // or with dst==src_s: 11|7
    drain();
    peek(0, 15);

    // Load and instruction together in IDLE: load wins, instruction follows next cycle.
    @(negedge clk);
    load_en = 1'b1; load_idx = 2'd2; load_data = 4'd5;
    set_instr(0, 3, 2, 1);
    in_valid = 1'b1;
    #1 check("load_blocks_ready", int'(in_ready), 0);
    @(negedge clk);
    load_en = 1'b0;
    #1 check("ready_after_load", int'(in_ready), 1);
    push_exp(3, 12);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    peek(2, 5);

    // Load during ISSUE and WB must be ignored.
    @(negedge clk);
    set_instr(2, 3, 1, 2);
    in_valid = 1'b1;
    #1 check("and_ready", int'(in_ready), 1);
    push_exp(3, 5);
    @(negedge clk);
    in_valid = 1'b0;
    load_en = 1'b1; load_idx = 2'd1; load_data = 4'd0;
    @(negedge clk);
    @(negedge clk);
    load_en = 1'b0;
    drain();
    peek(1, 7);

    // Back-to-back: in_valid held high, r0 += r1 each accept.
    pulses = 0;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_instr(0, 0, 0, 1);
      in_valid = 1'b1;
      #1 check($sformatf("b2b_ready_%0d", i), int'(in_ready), b2b_ready[i]);
      if (in_ready && k < 3) begin
        push_exp(0, b2b_res[k]);
        k++;
        pulses++;
      end
    end
    in_valid = 1'b0;
    check("b2b_pulses", pulses, 3);
    drain();
    peek(0, 4);

    // Reset in the middle of ISSUE drops the instruction.
    @(negedge clk);
    set_instr(3, 3, 0, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_alu_sel", int'(alu_sel), 0);
    check("midrst_alu_rs", int'(alu_rs), 0);
    check("midrst_alu_rt", int'(alu_rt), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_dst", int'(out_dst), 0);
    for (int i = 0; i < 4; i++) peek(i, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    peek(3, 0);
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
